// File: rtl/keypad_digit_display.sv
// keypad_digit_display
// Keeps a two-key history (newest on the right digit, previous on the left)
// and time-multiplexes both common-anode digits over one shared segment bus.
// A blanking window separates every digit switch so the segment bus can
// settle before the next enable rises, which keeps ghosting off the display.

module keypad_digit_display #(
  parameter int unsigned REFRESH_CYCLES = 24000,  // cycles each digit is lit per phase
  parameter int unsigned BLANK_CYCLES   = 240     // cycles both digits are dark between phases
) (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active low
  input  logic       key_valid,  // one-cycle strobe, key_code holds a new key
  input  logic [3:0] key_code,
  output logic [6:0] seg,        // active-low {g,f,e,d,c,b,a}
  output logic       en1,        // left (older) digit enable, active high
  output logic       en2,        // right (newest) digit enable, active high
  output logic [7:0] digits      // {left, right} for debug
);

  // Phase counter must hold the larger of the two phase lengths minus one.
  localparam int unsigned MAX_CYCLES = (REFRESH_CYCLES > BLANK_CYCLES) ?
                                       REFRESH_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One-hot refresh states.
  typedef enum logic [3:0] {
    ST_BLANK_TO_RIGHT = 4'b0001,
    ST_SHOW_RIGHT     = 4'b0010,
    ST_BLANK_TO_LEFT  = 4'b0100,
    ST_SHOW_LEFT      = 4'b1000
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             en1_q;
  logic             en2_q;

  logic [3:0]       left_q,        left_d;
  logic [3:0]       right_q,       right_d;
  logic             left_valid_q,  left_valid_d;
  logic             right_valid_q, right_valid_d;

  logic [6:0]       seg_q,         seg_d;
  logic [3:0]       sel_code;
  logic             sel_valid;

  // Hex value to active-low segment pattern, bit 0 = segment a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

  // Refresh sequencer; the enables are flops set on entry to the show states
  // so they never glitch and can never overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BLANK_TO_RIGHT;
      cnt_q   <= '0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_BLANK_TO_RIGHT: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= ST_SHOW_RIGHT;
            cnt_q   <= '0;
            en2_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        ST_SHOW_RIGHT: begin
          if (cnt_q == REFRESH_LAST) begin
            state_q <= ST_BLANK_TO_LEFT;
            cnt_q   <= '0;
            en2_q   <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        ST_BLANK_TO_LEFT: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= ST_SHOW_LEFT;
            cnt_q   <= '0;
            en1_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        ST_SHOW_LEFT: begin
          if (cnt_q == REFRESH_LAST) begin
            state_q <= ST_BLANK_TO_RIGHT;
            cnt_q   <= '0;
            en1_q   <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          // Illegal encoding: fall back to a dark, known-good restart point.
          state_q <= ST_BLANK_TO_RIGHT;
          cnt_q   <= '0;
          en1_q   <= 1'b0;
          en2_q   <= 1'b0;
        end
      endcase
    end
  end

  // Shift the history one place on every strobe; the new key is always valid.
  always_comb begin
    left_d        = left_q;
    right_d       = right_q;
    left_valid_d  = left_valid_q;
    right_valid_d = right_valid_q;
    if (key_valid) begin
      left_d        = right_q;
      left_valid_d  = right_valid_q;
      right_d       = key_code;
      right_valid_d = 1'b1;
    end
  end

  // Digit history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_q        <= 4'h0;
      right_q       <= 4'h0;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
    end else begin
      left_q        <= left_d;
      right_q       <= right_d;
      left_valid_q  <= left_valid_d;
      right_valid_q <= right_valid_d;
    end
  end

  // Pick the digit that belongs to the current half of the refresh period;
  // the blank state ahead of each show state already selects its digit.
  always_comb begin
    sel_code  = right_q;
    sel_valid = right_valid_q;
    if ((state_q == ST_BLANK_TO_LEFT) || (state_q == ST_SHOW_LEFT)) begin
      sel_code  = left_q;
      sel_valid = left_valid_q;
    end
    seg_d = sel_valid ? hex_to_seg(sel_code) : SEG_BLANK;
  end

  // Segment bus register, reloaded every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_BLANK;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg    = seg_q;
  assign en1    = en1_q;
  assign en2    = en2_q;
  assign digits = {left_q, right_q};

endmodule

// File: tb/tb_keypad_digit_display.sv
// Testbench for keypad_digit_display with REFRESH_CYCLES=8, BLANK_CYCLES=2.
// Cycle n refers to the values present just before clock edge n, where edge 0
// is the first edge after reset is released.

module tb_keypad_digit_display;

  localparam int PERIOD = 20;  // 2 * (8 + 2)
  localparam logic [6:0] BLK = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [6:0] seg;
  logic       en1;
  logic       en2;
  logic [7:0] digits;

  keypad_digit_display #(
    .REFRESH_CYCLES(8),
    .BLANK_CYCLES  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_valid(key_valid),
    .key_code (key_code),
    .seg      (seg),
    .en1      (en1),
    .en2      (en2),
    .digits   (digits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [7:0] digits;
    logic [6:0] seg_r;
    logic [6:0] seg_l;
  } vec_t;

  vec_t vecs [18];

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] exp_digits;
  logic [6:0] exp_r;
  logic [6:0] exp_l;
  bit         skip_seg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Compare this cycle's outputs against the timing model and expectations,
  // then advance one clock.
  task automatic tick();
    int  p;
    logic x_en1, x_en2;
    p     = cyc % PERIOD;
    x_en2 = (p >= 2) && (p <= 9);
    x_en1 = (p >= 12);
    check("en2", 32'(en2), 32'(x_en2));
    check("en1", 32'(en1), 32'(x_en1));
    check("en_overlap", 32'(en1 & en2), 32'd0);
    check("digits", 32'(digits), 32'(exp_digits));
    if (!skip_seg) begin
      if (en2)
        check("seg_right", 32'(seg), 32'(exp_r));
      else if (en1)
        check("seg_left", 32'(seg), 32'(exp_l));
      else if ((exp_r == BLK) && (exp_l == BLK))
        check("seg_idle", 32'(seg), 32'(BLK));
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic press(input logic [3:0] code, input logic [7:0] new_digits);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid  = 1'b0;
    exp_digits = new_digits;
    skip_seg   = 1'b1;
  endtask

  task automatic settle(input logic [6:0] r, input logic [6:0] l);
    tick();
    skip_seg = 1'b0;
    exp_r    = r;
    exp_l    = l;
  endtask

  task automatic run_vec(input int i);
    press(vecs[i].code, vecs[i].digits);
    settle(vecs[i].seg_r, vecs[i].seg_l);
    check("digits_tab", 32'(digits), 32'(vecs[i].digits));
    repeat (PERIOD) tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_seg"},    32'(seg),    32'(BLK));
    check({tag, "_en1"},    32'(en1),    32'd0);
    check({tag, "_en2"},    32'(en2),    32'd0);
    check({tag, "_digits"}, 32'(digits), 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{4'h6, 8'h06, 7'b0000010, 7'b1111111};
    vecs[1]  = '{4'hA, 8'h6A, 7'b0001000, 7'b0000010};
    vecs[2]  = '{4'h0, 8'h30, 7'b1000000, 7'b0110000};
    vecs[3]  = '{4'h1, 8'h01, 7'b1111001, 7'b1000000};
    vecs[4]  = '{4'h2, 8'h12, 7'b0100100, 7'b1111001};
    vecs[5]  = '{4'h3, 8'h23, 7'b0110000, 7'b0100100};
    vecs[6]  = '{4'h4, 8'h34, 7'b0011001, 7'b0110000};
    vecs[7]  = '{4'h5, 8'h45, 7'b0010010, 7'b0011001};
    vecs[8]  = '{4'h6, 8'h56, 7'b0000010, 7'b0010010};
    vecs[9]  = '{4'h7, 8'h67, 7'b1111000, 7'b0000010};
    vecs[10] = '{4'h8, 8'h78, 7'b0000000, 7'b1111000};
    vecs[11] = '{4'h9, 8'h89, 7'b0010000, 7'b0000000};
    vecs[12] = '{4'hA, 8'h9A, 7'b0001000, 7'b0010000};
    vecs[13] = '{4'hB, 8'hAB, 7'b0000011, 7'b0001000};
    vecs[14] = '{4'hC, 8'hBC, 7'b1000110, 7'b0000011};
    vecs[15] = '{4'hD, 8'hCD, 7'b0100001, 7'b1000110};
    vecs[16] = '{4'hE, 8'hDE, 7'b0000110, 7'b0100001};
    vecs[17] = '{4'hF, 8'hEF, 7'b0001110, 7'b0000110};

    reset      = 1'b0;
    key_valid  = 1'b0;
    key_code   = 4'h0;
    exp_digits = 8'h00;
    exp_r      = BLK;
    exp_l      = BLK;
    skip_seg   = 1'b0;

    // Reset state, then release on a falling edge.
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    cyc   = 0;

    // Scenario 1: two full refresh periods with no keys.
    repeat (2 * PERIOD) tick();

    // Scenario 3: key 6 then key A.
    for (int i = 0; i < 2; i++) run_vec(i);

    // Scenario 5: asynchronous reset in the middle of SHOW_LEFT.
    while ((cyc % PERIOD) != 14) tick();
    check("pre_reset_en1", 32'(en1), 32'd1);
    check("pre_reset_digits", 32'(digits), 32'h6A);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #1;
    check_reset_values("held");
    @(negedge clk);
    reset      = 1'b1;
    cyc        = 0;
    exp_digits = 8'h00;
    exp_r      = BLK;
    exp_l      = BLK;

    // Scenario 2: single key 6 strobed at cycle 5 after the restart.
    while (cyc < 5) tick();
    press(4'h6, 8'h06);
    settle(7'b0000010, BLK);
    repeat (PERIOD) tick();

    // Scenario 4: key_valid held three cycles with codes 1, 2, 3.
    press(4'h1, 8'h61);
    press(4'h2, 8'h12);
    press(4'h3, 8'h23);
    settle(7'b0110000, 7'b0100100);
    repeat (PERIOD) tick();

    // Scenario 6: sweep all sixteen codes.
    for (int i = 2; i < 18; i++) run_vec(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_digit_display.md
Name: keypad_digit_display

Overview:
- Downstream consumer of the keypad scanner/debouncer.
- Takes a one-cycle key strobe plus a 4-bit hex key code and keeps a two-digit history: the newest key on the right digit, the previous key on the left digit.
- Time-multiplexes the two common-anode seven-segment digits through a shared segment bus, with a blanking gap between digit switches to prevent ghosting.
- Its outputs drive the board-level seg, en1 and en2 pins.

Parameters:
- REFRESH_CYCLES, 24000, clock cycles each digit is enabled per refresh phase (must be ≥ 1).
- BLANK_CYCLES, 240, clock cycles both digits are disabled between phases (must be ≥ 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- key_valid  input  1  one-cycle strobe: key_code holds a newly pressed key.
- key_code  input  4  hex value of the pressed key, 0x0–0xF.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}, bit 0 = a.
- en1  output  1  active-high enable, left (older) digit.
- en2  output  1  active-high enable, right (newest) digit.
- digits  output  8  {left, right} digit registers, for debug.

Behaviour:
- Reset (reset low, asynchronous):
  - left = right = 0; both valid flags = 0.
  - State = BLANK_TO_RIGHT, phase counter = 0.
  - seg = 7'b1111111, en1 = en2 = 0.
- Digit history:
  - On a rising clk edge with key_valid = 1: left <= right; left_valid <= right_valid; right <= key_code; right_valid <= 1.
  - key_valid high for N consecutive cycles performs N shifts. The upstream block guarantees one pulse per press.
  - There is no wrap concern; history depth is exactly 2.
- Refresh FSM (one-hot, four states, phase counter 0..max−1):
  - BLANK_TO_RIGHT: lasts BLANK_CYCLES cycles, then goes to SHOW_RIGHT.
  - SHOW_RIGHT: lasts REFRESH_CYCLES cycles, then goes to BLANK_TO_LEFT.
  - BLANK_TO_LEFT: lasts BLANK_CYCLES cycles, then goes to SHOW_LEFT.
  - SHOW_LEFT: lasts REFRESH_CYCLES cycles, then goes to BLANK_TO_RIGHT.
  - The counter clears on every state transition.
  - Full period = 2 × (REFRESH_CYCLES + BLANK_CYCLES) cycles.
- Enables:
  - en2 = state flop SHOW_RIGHT; en1 = state flop SHOW_LEFT. Both are driven directly from flops, so they are glitch-free.
  - en1 and en2 are never high in the same cycle.
- Segment bus:
  - seg is a register loaded every cycle.
  - The selected digit is right in BLANK_TO_RIGHT/SHOW_RIGHT and left in BLANK_TO_LEFT/SHOW_LEFT.
  - If the selected digit's valid flag = 0, seg loads 7'b1111111 (blank). Otherwise it loads the hex pattern.
  - seg therefore settles during each blank window before the matching enable rises.
- Latency: key_valid sampled at edge k → digits updated at edge k; seg reflects the new value at edge k+1 if that digit is currently selected.
- A key arriving during any state updates the registers immediately and does not disturb FSM timing.
- Hex patterns (seg[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-phase: all outputs return to their reset values immediately (asynchronous). After release, the FSM restarts at BLANK_TO_RIGHT with counter 0.

Test Plan:
Run all scenarios with REFRESH_CYCLES=8 and BLANK_CYCLES=2. Cycle 0 is the first edge after reset deasserts.
1. Reset, no keys:
   - Cycles 0–1: en1 = en2 = 0.
   - Cycles 2–9: en2 = 1.
   - Cycles 10–11: both 0.
   - Cycles 12–19: en1 = 1.
   - Repeats at cycle 20.
   - seg = 1111111 throughout; en1 & en2 never both 1.
2. Single key 0x6 pulsed at cycle 5:
   - digits = 8'h06 after that edge.
   - seg = 0000010 whenever en2 = 1 (from cycle 6).
   - seg = 1111111 whenever en1 = 1.
3. Key 0x6 then key 0xA:
   - digits = 8'h6A.
   - seg = 0001000 while en2 = 1; seg = 0000010 while en1 = 1.
4. key_valid held high 3 cycles with codes 1, 2, 3:
   - digits = 8'h23.
   - Left shows 0100100; right shows 0110000.
5. Reset pulsed low mid-SHOW_LEFT with digits = 8'h6A:
   - seg = 1111111, en1 = en2 = 0, and digits = 0 immediately.
   - Both digits blank after release.
   - FSM timing restarts exactly as in scenario 1.
6. Sweep all 16 codes, each followed by a full period:
   - seg matches the hex pattern list for every code while en2 = 1.
